// File: rtl/dl_reg_rr_arb_if.sv
// Handshake/bus bundle for dl_reg_rr_arb.
//   req_valid / req_data / req_ready : NUM_REQ producer channels; requester i
//                                      data sits at [i*NUM_BITS +: NUM_BITS]
//   q / q_valid / q_owner / q_ready  : single consumer channel from the shared
//                                      holding register
// Modports: slave = arbiter side, master = producer/consumer environment.
interface dl_reg_rr_arb_if #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned NUM_BITS = 32,
  parameter int unsigned IDX_W    = $clog2(NUM_REQ)
);
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ*NUM_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_BITS-1:0]         q;
  logic                        q_valid;
  logic [IDX_W-1:0]            q_owner;
  logic                        q_ready;

  modport master (
    output req_valid, req_data, q_ready,
    input  req_ready, q, q_valid, q_owner
  );

  modport slave (
    input  req_valid, req_data, q_ready,
    output req_ready, q, q_valid, q_owner
  );
endinterface

// File: rtl/dl_reg_rr_arb.sv
// Round-robin arbiter feeding a shared one-entry holding register.
// Each cycle at most one valid requester is granted (search starts at the
// priority pointer and wraps), its data is loaded into q and presented to a
// single consumer with a valid/ready handshake. Pop-and-load in one cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : dl_reg_rr_arb_if.slave (request channels in, q channel out)
module dl_reg_rr_arb #(
  parameter int unsigned         NUM_REQ  = 4,
  parameter int unsigned         NUM_BITS = 32,
  parameter logic [NUM_BITS-1:0] RST_VAL  = '0,
  parameter int unsigned         IDX_W    = $clog2(NUM_REQ)
) (
  input  logic              clk,
  input  logic              rst_n,
  dl_reg_rr_arb_if.slave    bus
);

  logic [NUM_BITS-1:0] q_q, q_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                full_q, full_d;

  logic                found_hi, found_lo;
  logic [IDX_W-1:0]    idx_hi, idx_lo;
  logic [IDX_W-1:0]    gnt_idx;
  logic                gnt_found;
  logic [NUM_BITS-1:0] gnt_data;
  logic                can_load;
  logic                load;
  logic [NUM_REQ-1:0]  req_ready_c;

  // Wrapping search split in two passes: first valid index at or above ptr,
  // otherwise first valid index overall. Loop-constant indexing keeps the
  // logic a plain priority encoder.
  always_comb begin
    found_hi = 1'b0;
    found_lo = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found_hi && bus.req_valid[i] && (IDX_W'(i) >= ptr_q)) begin
        found_hi = 1'b1;
        idx_hi   = IDX_W'(i);
      end
      if (!found_lo && bus.req_valid[i]) begin
        found_lo = 1'b1;
        idx_lo   = IDX_W'(i);
      end
    end
    gnt_found = found_lo;
    gnt_idx   = found_hi ? idx_hi : idx_lo;
  end

  // Data mux is kept off the req_ready path: req_data only reaches q_d.
  always_comb begin
    gnt_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDX_W'(i)) begin
        gnt_data = bus.req_data[i*NUM_BITS +: NUM_BITS];
      end
    end
  end

  assign can_load = !full_q || bus.q_ready;
  assign load     = gnt_found && can_load && rst_n;

  always_comb begin
    req_ready_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      req_ready_c[i] = load && (gnt_idx == IDX_W'(i));
    end
  end

  always_comb begin
    q_d     = q_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    full_d  = full_q;
    if (load) begin
      q_d     = gnt_data;
      owner_d = gnt_idx;
      full_d  = 1'b1;
      ptr_d   = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (full_q && bus.q_ready) begin
      full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q     <= RST_VAL;
      owner_q <= '0;
      ptr_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      full_q  <= full_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.q         = q_q;
  assign bus.q_valid   = full_q;
  assign bus.q_owner   = owner_q;

endmodule

// File: tb/tb_dl_reg_rr_arb.sv
// Self-checking bench for dl_reg_rr_arb (NUM_REQ=4, NUM_BITS=32,
// RST_VAL=c0ffee69). Directed phases check hand-computed owner/data
// sequences; a reference process predicts each grant, checks req_ready and
// pushes the expected datum into a scoreboard queue that a monitor drains on
// every consumer pop.
module tb_dl_reg_rr_arb;
  localparam int unsigned NR = 4;
  localparam int unsigned NB = 32;
  localparam logic [31:0] RV = 32'hc0ffee69;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  owner;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dl_reg_rr_arb_if #(.NUM_REQ(NR), .NUM_BITS(NB)) bus ();

  dl_reg_rr_arb #(.NUM_REQ(NR), .NUM_BITS(NB), .RST_VAL(RV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [1:0]  mptr = 2'd0;
  int          waits[NR];
  logic [31:0] dat[NR];

  always_comb begin
    bus.req_data = '0;
    for (int unsigned i = 0; i < NR; i++) bus.req_data[i*NB +: NB] = dat[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a pop happens at the coming edge when q_valid && q_ready.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("q_valid", 32'(bus.q_valid), 32'(sb.size() != 0));
      if (bus.q_valid === 1'b1 && bus.q_ready === 1'b1 && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("pop_data", bus.q, e.data);
        chk("pop_owner", 32'(bus.q_owner), 32'(e.owner));
      end
    end
  end

  // Reference grant model, run after the monitor has retired any pop.
  always @(negedge clk) begin
    #1;
    if (rst_n !== 1'b1) begin
      chk("ready_in_reset", 32'(bus.req_ready), 32'd0);
      sb.delete();
      mptr = 2'd0;
      for (int unsigned i = 0; i < NR; i++) waits[i] = 0;
    end else begin
      bit          found;
      int unsigned g;
      int unsigned idx;
      logic [3:0]  expr;
      logic [3:0]  xfer;
      found = 1'b0;
      g     = 0;
      for (int unsigned k = 0; k < NR; k++) begin
        idx = (32'(mptr) + k) % NR;
        if (!found && bus.req_valid[idx[1:0]]) begin
          found = 1'b1;
          g     = idx;
        end
      end
      expr = '0;
      if (found && sb.size() == 0) expr[g[1:0]] = 1'b1;
      chk("req_ready", 32'(bus.req_ready), 32'(expr));
      if (expr != 4'd0) begin
        exp_t e;
        e.data  = dat[g[1:0]];
        e.owner = g[1:0];
        sb.push_back(e);
        mptr = (g == NR - 1) ? 2'd0 : 2'(g + 1);
      end
      xfer = bus.req_valid & bus.req_ready;
      if (xfer != 4'd0) begin
        for (int unsigned i = 0; i < NR; i++) begin
          if (!bus.req_valid[i] || xfer[i]) waits[i] = 0;
          else begin
            waits[i]++;
            chk("fairness", 32'(waits[i] < NR), 32'd1);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_q(input string name, input logic [31:0] d, input logic [1:0] o, input logic v);
    chk({name, "_q"}, bus.q, d);
    chk({name, "_owner"}, 32'(bus.q_owner), 32'(o));
    chk({name, "_valid"}, 32'(bus.q_valid), 32'(v));
  endtask

  initial begin
    int unsigned seq_owner[7] = '{1, 2, 3, 0, 1, 2, 3};
    int unsigned alt_owner[4] = '{1, 3, 1, 3};
    logic [3:0]  xfer;
    logic        rst_was;
    int unsigned seq;

    // Reset with every requester asking.
    rst_n         = 1'b0;
    bus.req_valid = 4'b1111;
    bus.q_ready   = 1'b1;
    for (int unsigned i = 0; i < NR; i++) dat[i] = 32'h1000_0000 + i;
    repeat (2) begin
      cyc();
      chk_q("reset", RV, 2'd0, 1'b0);
      chk("reset_ready", 32'(bus.req_ready), 32'd0);
    end

    rst_n = 1'b1;
    #1 chk("first_grant", 32'(bus.req_ready), 32'h1);
    cyc();
    chk_q("rr0", 32'h1000_0000, 2'd0, 1'b1);
    foreach (seq_owner[j]) begin
      cyc();
      chk_q("rr", 32'h1000_0000 + seq_owner[j], 2'(seq_owner[j]), 1'b1);
    end

    // Only 1 and 3 valid: pointer wraps 3->0, next winner is 1.
    bus.req_valid = 4'b1010;
    foreach (alt_owner[j]) begin
      cyc();
      chk_q("alt", 32'h1000_0000 + alt_owner[j], 2'(alt_owner[j]), 1'b1);
    end

    // Back-pressure.
    bus.req_valid = 4'b0100;
    dat[2]        = 32'hdeadbeef;
    cyc();
    chk_q("bp_load", 32'hdeadbeef, 2'd2, 1'b1);
    bus.req_valid = 4'b0001;
    bus.q_ready   = 1'b0;
    repeat (5) begin
      #1 chk("bp_ready", 32'(bus.req_ready), 32'd0);
      cyc();
      chk_q("bp_hold", 32'hdeadbeef, 2'd2, 1'b1);
    end
    bus.q_ready = 1'b1;
    #1 chk("bp_release", 32'(bus.req_ready), 32'h1);
    cyc();
    chk_q("bp_popload", 32'h1000_0000, 2'd0, 1'b1);

    // Drain with no requests; pointer must stay at 1.
    bus.req_valid = 4'b0000;
    cyc();
    chk_q("drain", 32'h1000_0000, 2'd0, 1'b0);
    bus.req_valid = 4'b1111;
    bus.q_ready   = 1'b0;
    #1 chk("ptr_kept", 32'(bus.req_ready), 32'h2);
    cyc();
    chk_q("ptr_load", 32'h1000_0001, 2'd1, 1'b1);

    // Reset while full and requester 3 would be granted.
    bus.req_valid = 4'b1000;
    bus.q_ready   = 1'b1;
    rst_n         = 1'b0;
    #1 chk("midrst_ready", 32'(bus.req_ready), 32'd0);
    cyc();
    chk_q("midrst", RV, 2'd0, 1'b0);
    rst_n         = 1'b1;
    bus.req_valid = 4'b1111;
    #1 chk("midrst_ptr", 32'(bus.req_ready), 32'h1);
    cyc();
    chk_q("midrst_load", 32'h1000_0000, 2'd0, 1'b1);

    // Random traffic; requesters hold valid/data until granted.
    seq = 0;
    repeat (500) begin
      @(negedge clk);
      xfer    = bus.req_valid & bus.req_ready;
      rst_was = rst_n;
      @(posedge clk);
      #1;
      for (int unsigned i = 0; i < NR; i++) begin
        if (!bus.req_valid[i] || xfer[i] || !rst_was) begin
          bus.req_valid[i] = 1'($urandom_range(0, 1));
          dat[i]           = {8'(i), 24'(seq)};
          seq++;
        end
      end
      bus.q_ready = ($urandom_range(0, 3) != 0);
      rst_n       = ($urandom_range(0, 29) != 0);
    end

    rst_n         = 1'b1;
    bus.req_valid = 4'b0000;
    bus.q_ready   = 1'b1;
    repeat (3) cyc();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("end_valid", 32'(bus.q_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: run did not finish, got %0t expected < 100000", $time);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
